// File: rtl/vrc_cfg_pkg.sv
// Shared types and constants for the VRC configuration loader: widths,
// CRC-8 polynomial, FSM state encoding and the bit-serial CRC step.
package vrc_cfg_pkg;

  localparam int CFG_W = 86;
  localparam int CRC_W = 8;
  localparam int CNT_W = $clog2(CFG_W);
  localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CRC,
    COMMIT
  } state_t;

  // One MSB-first CRC step: init 0, no reflection, no final XOR
  function automatic logic [CRC_W-1:0] crc8_next(input logic [CRC_W-1:0] crc,
                                                 input logic din);
    logic fb;
    fb = crc[CRC_W-1] ^ din;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/vrc_cfg_tmr_reg.sv
// Triple-redundant word register with majority vote and per-cycle scrubbing.
// Used by vrc_cfg_loader only when VRC_CFG_TMR_EN is defined.
module vrc_cfg_tmr_reg
  import vrc_cfg_pkg::*;
#(
  parameter int         W       = CFG_W,
  parameter logic [W:1] RST_VAL = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [W:1] wr_data,
  output logic [W:1] q,
  output logic       fault
);

  logic [W:1] copies [3];
  logic [W:1] vote;
  logic       mismatch;
  logic       fault_q;

  assign vote = (copies[0] & copies[1]) | (copies[0] & copies[2]) | (copies[1] & copies[2]);
  assign mismatch = (copies[0] != vote) | (copies[1] != vote) | (copies[2] != vote);

  // Writing the vote back every cycle repairs any single upset copy
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_copy
      logic [W:1] copy_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) copy_q <= RST_VAL;
        else        copy_q <= wr_en ? wr_data : vote;
      end
      assign copies[gi] = copy_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= mismatch & ~wr_en;
  end

  assign q     = vote;
  assign fault = fault_q;

endmodule

// File: rtl/vrc_cfg_loader.sv
// Serial CRC-protected configuration loader driving the VRC Sel word.
// Optional triple-redundant Sel storage when VRC_CFG_TMR_EN is defined.
module vrc_cfg_loader
  import vrc_cfg_pkg::*;
#(
  parameter logic [CFG_W:1] SEL_RST = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_start,
  input  logic           cfg_valid,
  input  logic           cfg_bit,
  output logic           cfg_ready,
  output logic           busy,
  output logic           cfg_done,
  output logic           cfg_err,
  output logic           sel_fault,
  output logic [CFG_W:1] Sel
);

  localparam logic [CNT_W-1:0] LAST_CFG = CNT_W'(CFG_W - 1);
  localparam logic [CNT_W-1:0] LAST_CRC = CNT_W'(CRC_W - 1);

  state_t           state_q;
  logic [CFG_W:1]   shadow_q;
  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] rx_crc_q;
  logic [CNT_W-1:0] count_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             accept;
  logic             commit_en;

  assign accept    = cfg_valid & ready_q;
  assign commit_en = (state_q == COMMIT) && (rx_crc_q == crc_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      crc_q    <= '0;
      rx_crc_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_start) begin
            state_q <= LOAD;
            count_q <= '0;
            crc_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        LOAD, CRC: begin
          // A start strobe mid-frame discards the partial frame; it wins over a coincident bit
          if (cfg_start) begin
            state_q <= LOAD;
            count_q <= '0;
            crc_q   <= '0;
          end else if (accept) begin
            if (state_q == LOAD) begin
              shadow_q <= {shadow_q[CFG_W-1:1], cfg_bit};
              crc_q    <= crc8_next(crc_q, cfg_bit);
              if (count_q == LAST_CFG) begin
                state_q <= CRC;
                count_q <= '0;
              end else begin
                count_q <= count_q + 1'b1;
              end
            end else begin
              rx_crc_q <= {rx_crc_q[CRC_W-2:0], cfg_bit};
              if (count_q == LAST_CRC) begin
                state_q <= COMMIT;
                count_q <= '0;
                ready_q <= 1'b0;
              end else begin
                count_q <= count_q + 1'b1;
              end
            end
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= commit_en;
          err_q   <= ~commit_en;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef VRC_CFG_TMR_EN
  vrc_cfg_tmr_reg #(
    .W       (CFG_W),
    .RST_VAL (SEL_RST)
  ) u_tmr (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (commit_en),
    .wr_data (shadow_q),
    .q       (Sel),
    .fault   (sel_fault)
  );
`else
  logic [CFG_W:1] sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         sel_q <= SEL_RST;
    else if (commit_en) sel_q <= shadow_q;
  end

  assign Sel       = sel_q;
  assign sel_fault = 1'b0;
`endif

  assign cfg_ready = ready_q;
  assign busy      = busy_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_vrc_cfg_loader.sv
// Randomized scoreboard bench for vrc_cfg_loader; golden CRC from polynomial
// long division. Define VRC_CFG_TMR_EN to also exercise the TMR repair path.
module tb_vrc_cfg_loader;
  import vrc_cfg_pkg::*;

  localparam logic [CFG_W:1] RST_VAL = 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_start = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_bit = 1'b0;
  logic           cfg_ready, busy, cfg_done, cfg_err, sel_fault;
  logic [CFG_W:1] Sel;

  vrc_cfg_loader #(.SEL_RST(RST_VAL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_ready (cfg_ready),
    .busy      (busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .sel_fault (sel_fault),
    .Sel       (Sel)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;
  int last_acc = 0;
  int fault_seen = 0;
  int done_seen = 0;
  int err_seen = 0;
  bit gaps_en = 1'b0;

  typedef struct {
    bit             is_done;
    logic [CFG_W:1] sel;
    int             acc_edge;
  } exp_t;

  exp_t           exp_q[$];
  exp_t           mon_e;
  logic [CFG_W:1] model_sel = RST_VAL;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Golden CRC: remainder of M(x)*x^8 divided by x^8+x^2+x+1
  function automatic logic [7:0] ref_crc(input logic [CFG_W:1] word);
    logic [CFG_W+7:0] r;
    r = {word, 8'h00};
    for (int i = CFG_W + 7; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0];
  endfunction

  // Monitor: pops the scoreboard whenever the DUT reports a frame outcome
  always @(negedge clk) begin
    if (!rst_n) begin
      model_sel = RST_VAL;
      exp_q.delete();
    end else begin
      if (sel_fault) fault_seen++;
`ifndef VRC_CFG_TMR_EN
      check("sel_fault_tied", sel_fault, 0);
`endif
      if (cfg_done || cfg_err) begin
        check("done_err_exclusive", cfg_done & cfg_err, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {cfg_done, cfg_err}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("outcome_done", cfg_done, mon_e.is_done);
          check("outcome_latency", edge_cnt - mon_e.acc_edge, 1);
          if (mon_e.is_done) begin
            model_sel = mon_e.sel;
            done_seen++;
          end else begin
            err_seen++;
          end
          check("sel_after_commit", Sel, model_sel);
          $display("frame %s sel=%0h", cfg_done ? "done" : "err", Sel);
        end
      end else begin
        check("sel_hold", Sel, model_sel);
      end
    end
  end

  task automatic start_frame(input bit with_valid);
    cfg_start = 1'b1;
    cfg_valid = with_valid;
    cfg_bit   = 1'($urandom);
    @(negedge clk);
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    if (gaps_en && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    cfg_valid = 1'b1;
    cfg_bit   = b;
    if (!cfg_ready) check("ready_in_frame", cfg_ready, 1);
    @(posedge clk);
    @(negedge clk);
    last_acc  = edge_cnt;
    cfg_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [CFG_W:1] word, input logic [7:0] crc,
                            input bit start_valid, input bit commit_start);
    exp_t e;
    start_frame(start_valid);
    check("busy_after_start", busy, 1);
    for (int i = CFG_W; i >= 1; i--) send_bit(word[i]);
    for (int i = 7; i >= 0; i--) send_bit(crc[i]);
    e.is_done  = (crc == ref_crc(word));
    e.sel      = word;
    e.acc_edge = last_acc;
    exp_q.push_back(e);
    check("ready_low_commit", cfg_ready, 0);
    if (commit_start) cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    @(negedge clk);
    check("busy_idle", busy, 0);
    check("ready_idle", cfg_ready, 0);
  endtask

  function automatic logic [CFG_W:1] rand_word();
    logic [CFG_W:1] w;
    for (int i = 1; i <= CFG_W; i++) w[i] = 1'($urandom);
    return w;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CFG_W:1] w;
    logic [7:0]     c;
    int             d0, e0, f0;

    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset_sel", Sel, RST_VAL);
    check("reset_ready", cfg_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_done_err", {cfg_done, cfg_err}, 0);

    // All-zero word with its (zero) CRC, then with a bad CRC
    send_frame('0, 8'h00, 1'b0, 1'b0);
    send_frame('0, 8'h01, 1'b0, 1'b0);

    // Random committed word, then a corrupted frame must leave it in place
    w = rand_word();
    send_frame(w, ref_crc(w), 1'b1, 1'b1);
    send_frame('0, 8'h01, 1'b0, 1'b0);

    // Random words with gaps; roughly one in four carries a corrupted CRC
    gaps_en = 1'b1;
    for (int n = 0; n < 10; n++) begin
      w = rand_word();
      c = ref_crc(w);
      if ($urandom_range(0, 3) == 0) c = c ^ 8'(1 << $urandom_range(0, 7));
      send_frame(w, c, 1'($urandom), 1'($urandom));
    end

    // Abort after 40 bits, then a full frame: exactly one done, no err
    d0 = done_seen;
    e0 = err_seen;
    start_frame(1'b0);
    for (int i = 0; i < 40; i++) send_bit(1'($urandom));
    w = rand_word();
    send_frame(w, ref_crc(w), 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("abort_single_done", done_seen - d0, 1);
    check("abort_no_err", err_seen - e0, 0);
    check("abort_sel", Sel, w);

    // Reset mid-frame: partial frame dropped, Sel back to reset value
    start_frame(1'b0);
    for (int i = 0; i < 30; i++) send_bit(1'($urandom));
    #2 rst_n = 1'b0;
    #1 check("midreset_sel", Sel, RST_VAL);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("midreset_busy", busy, 0);
    check("midreset_ready", cfg_ready, 0);
    w = rand_word();
    send_frame(w, ref_crc(w), 1'b0, 1'b0);

`ifdef VRC_CFG_TMR_EN
    begin
      logic [CFG_W:1] flip;
      f0   = fault_seen;
      flip = ~dut.u_tmr.g_copy[1].copy_q;
      force dut.u_tmr.g_copy[1].copy_q = flip;
      #1 release dut.u_tmr.g_copy[1].copy_q;
      check("tmr_sel_unchanged", Sel, w);
      @(negedge clk);
      check("tmr_copy_repaired", dut.u_tmr.g_copy[1].copy_q, w);
      @(negedge clk);
      check("tmr_fault_once", fault_seen - f0, 1);
    end
`else
    f0 = fault_seen;
    check("no_fault_seen", f0, 0);
`endif

    begin
      int waited = 0;
      while (exp_q.size() != 0 && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      check("scoreboard_drained", exp_q.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
